mips_prog_loader: RTL
=====================

// Module: mips_prog_loader
// PURPOSE
//  Writer side of the opcode/format interface that the MIPS control decoder consumes.
//  Accepts instruction descriptors over a valid/ready handshake and encodes them into 32-bit MIPS words.
//  Writes the words sequentially into instruction memory from BASE_ADDR.
//  Used by test benches and the boot path to load programs the CPU then fetches and decodes.
// PARAMETERS
//  ADDR_W     8   word-address width of instruction memory (legal range 2..16)
//  BASE_ADDR  0   first word address written after start
// PORTS
//  clk         in   1       clock; all state changes on the rising edge
//  reset       in   1       synchronous, active-high reset
//  start       in   1       begin a load; honoured in IDLE and DONE, ignored in LOAD
//  in_valid    in   1       descriptor valid
//  in_ready    out  1       loader can accept a descriptor
//  in_op       in   3       0=R-type 1=addi 2=lw 3=sw 4=andi 5=beq 6=jal 7=END
//  in_funct    in   6       R-type funct
//  in_rs       in   5       rs field
//  in_rt       in   5       rt field
//  in_rd       in   5       rd field
//  in_shamt    in   5       shamt field
//  in_imm      in   16      immediate for addi/lw/sw/andi
//  in_target   in   ADDR_W  absolute word address for beq/jal
//  imem_we     out  1       instruction-memory write strobe
//  imem_addr   out  ADDR_W  write word address
//  imem_wdata  out  32      encoded instruction
//  busy        out  1       high in LOAD
//  done        out  1       high in DONE
//  err         out  1       sticky error; cleared by start or reset
//  count       out  ADDR_W+1  words written in the current load
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, imem_we, busy, done and err =0; count=0; imem_addr=BASE_ADDR; imem_wdata=0.
//  FSM IDLE -> LOAD on start. On entry: addr=BASE_ADDR, count=0, err=0.
//  LOAD: in_ready=1. A descriptor is accepted when in_valid & in_ready are both high at a rising edge.
//  Accepted END: no write; next state DONE.
//  Accepted encodable op accepted at edge N, when count < 2^ADDR_W:
//   - During cycle N+1: imem_we=1, and imem_addr/imem_wdata hold the registered address and word.
//   - addr and count are incremented.
//   - Back-to-back accepts give one write per cycle.
//   - imem_we=0 in any cycle with no new write.
//  Encodings (op field in bits 31:26):
//   - R-type: {6'h00, rs, rt, rd, shamt, funct}.
//     Legal funct: 0x20 add, 0x24 and, 0x27 nor, 0x08 jr, 0x2A slt, 0x00 sll.
//   - addi 0x08, lw 0x23, sw 0x2B, andi 0x0C: {op, rs, rt, imm}.
//   - beq 0x04: {op, rs, rt, off16}, where off16 = in_target - (addr+1), as signed 17-bit arithmetic.
//   - jal 0x03: {op, 26'(in_target)}, zero-extended.
//  Errors: each error sets err=1, performs no write, and moves to DONE.
//   - Illegal R-type funct.
//   - beq offset outside [-32768, 32767]. Possible only when ADDR_W=16.
//   - Accept while count == 2^ADDR_W (memory full). Address never wraps.
//  DONE: done=1 and in_ready=0; err and count are held. start begins a new load, as from IDLE.
//  Reset mid-load: the FSM returns to IDLE; imem_we=0 from the next cycle. Partial contents in memory are not undone.
//  start together with reset: reset wins.
//  in_valid in IDLE or DONE is ignored (in_ready=0).
// TESTING
//  1. start; add rs=1,rt=2,rd=3,funct=0x20 -> one cycle later imem_we=1, addr=0, wdata=0x00221820; count=1.
//  2. addi rs=0,rt=2,imm=5, then lw rs=9,rt=8,imm=4, back-to-back
//     -> writes 0x20020005 @0 and 0x8D280004 @1 on consecutive cycles.
//  3. Three fillers @0..2, then beq rs=1,rt=2,target=0
//     -> write @3 = 0x1022FFFC; then jal target=0x10 -> write @4 = 0x0C000010.
//  4. R-type funct=0x3F -> err=1, done=1, no imem_we; a new start clears err and restarts at addr 0.
//  5. ADDR_W=2: four writes then a fifth descriptor -> err=1, count=4, no wrap write to addr 0.
//  6. Reset asserted while in_valid is streaming -> IDLE, in_ready=0, imem_we=0 the next cycle; then END after start -> done=1, count=0.

Source files
------------

// File: rtl/mips_prog_loader_if.sv
// Descriptor handshake, instruction-memory write port and load status for the MIPS program loader.
// master = the side that issues descriptors; slave = the loader.
interface mips_prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [5:0]        in_funct;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [ADDR_W-1:0] in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, in_op, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );

  modport slave (
    input  start, in_valid, in_op, in_funct, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );
endinterface

// File: rtl/mips_prog_loader.sv
// Encodes instruction descriptors into 32-bit MIPS words and writes them sequentially
// into instruction memory starting at BASE_ADDR.
module mips_prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  mips_prog_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0]   FULL   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
  localparam logic [2:0]        OP_END = 3'd7;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       wdata_q;
  logic              we_q, ready_q, busy_q, done_q, err_q;

  logic              accept;
  logic [31:0]       word_d;
  logic              bad_d;
  logic signed [16:0] off;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h24, 6'h27, 6'h08, 6'h2A, 6'h00: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  assign accept = bus.in_valid & ready_q;

  // beq offset is relative to the word after the branch being written.
  always_comb begin
    word_d = '0;
    bad_d  = 1'b0;
    off    = 17'(bus.in_target) - 17'(addr_q) - 17'd1;
    case (bus.in_op)
      3'd0: begin
        word_d = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
        bad_d  = !funct_legal(bus.in_funct);
      end
      3'd1: word_d = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd2: word_d = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd3: word_d = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4: word_d = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd5: begin
        word_d = {6'h04, bus.in_rs, bus.in_rt, off[15:0]};
        bad_d  = off[16] ^ off[15];
      end
      3'd6:    word_d = {6'h03, 26'(bus.in_target)};
      default: word_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= BASE;
      waddr_q <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= LOAD;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (bus.in_op == OP_END || bad_d || count_q == FULL) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= (bus.in_op != OP_END);
            end else begin
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= word_d;
              addr_q  <= addr_q + 1'b1;
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.count      = count_q;
endmodule
